pc_branch_unit: RTL and testbench

- Per-thread program-counter generator; the next generation of the core's PC logic.
- Parametrised address width.
- Adds NZP condition register with BRnzp branching, CALL/RET through a small return-address stack, and sticky error flags.
- Sits beside the decoder/ALU in each thread lane; the scheduler consumes next_pc.

---
 rtl/pc_branch_unit_pkg.sv | 26 ++
 rtl/pc_branch_unit_if.sv | 39 +++
 rtl/pc_ret_stack.sv | 46 ++++
 rtl/pc_branch_unit.sv | 101 ++++++++++
 tb/tb_pc_branch_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/pc_branch_unit_pkg.sv
// Shared definitions for the PC/branch unit: core-state encodings, NZP bit
// positions and the next-PC source selector.
`ifndef CORE_EXECUTE
`define CORE_EXECUTE 3'b101
`endif
`ifndef CORE_UPDATE
`define CORE_UPDATE 3'b110
`endif

package pc_branch_unit_pkg;

  localparam logic [2:0] CORE_STATE_EXECUTE = `CORE_EXECUTE;
  localparam logic [2:0] CORE_STATE_UPDATE  = `CORE_UPDATE;

  localparam int NZP_N = 2;
  localparam int NZP_Z = 1;
  localparam int NZP_P = 0;

  typedef enum logic [1:0] {
    SRC_RET,
    SRC_CALL,
    SRC_BRANCH,
    SRC_SEQ
  } pc_src_e;

endpackage

// File: rtl/pc_branch_unit_if.sv
// Decode/execute bus between a thread lane and its PC/branch unit.
// master = decoder/scheduler side, slave = pc_branch_unit.
interface pc_branch_unit_if #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int STACK_DEPTH = 4
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic              enable;
  logic [2:0]        core_state;
  logic [ADDR_W-1:0] current_pc;
  logic              decoded_pc_mux;
  logic [2:0]        decoded_nzp;
  logic [ADDR_W-1:0] decoded_imm;
  logic              decoded_call;
  logic              decoded_ret;
  logic              decoded_nzp_write_en;
  logic [DATA_W-1:0] alu_out;

  logic [ADDR_W-1:0]  next_pc;
  logic [2:0]         nzp;
  logic [DEPTH_W-1:0] stack_depth;
  logic               stack_overflow;
  logic               stack_underflow;
  logic               pc_fault;

  modport master (
    output enable, core_state, current_pc, decoded_pc_mux, decoded_nzp,
           decoded_imm, decoded_call, decoded_ret, decoded_nzp_write_en, alu_out,
    input  next_pc, nzp, stack_depth, stack_overflow, stack_underflow, pc_fault
  );

  modport slave (
    input  enable, core_state, current_pc, decoded_pc_mux, decoded_nzp,
           decoded_imm, decoded_call, decoded_ret, decoded_nzp_write_en, alu_out,
    output next_pc, nzp, stack_depth, stack_overflow, stack_underflow, pc_fault
  );
endinterface

// File: rtl/pc_ret_stack.sv
// Return-address LIFO for CALL/RET. Caller never asserts push and pop together;
// push is ignored when full, pop when empty.
module pc_ret_stack #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               push,
  input  logic                               pop,
  input  logic [ADDR_W-1:0]                  push_data,
  output logic [ADDR_W-1:0]                  top,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               full,
  output logic                               empty
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic [ADDR_W-1:0] entries [STACK_DEPTH];

  assign full  = (depth == DEPTH_W'(STACK_DEPTH));
  assign empty = (depth == '0);

  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (DEPTH_W'(i + 1) == depth) top = entries[i];
    end
  end

  // NOTE: entries are reset explicitly because a mid-run reset must leave no
  // stale return addresses; this keeps the array in flops rather than RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      depth <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) entries[i] <= '0;
    end else if (push && !full) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (DEPTH_W'(i) == depth) entries[i] <= push_data;
      end
      depth <= depth + DEPTH_W'(1);
    end else if (pop && !empty) begin
      depth <= depth - DEPTH_W'(1);
    end
  end
endmodule

// File: rtl/pc_branch_unit.sv
// Per-thread next-PC generator with NZP branching, CALL/RET stack and sticky
// error flags. Define PC_BOUND_CHECK_EN to fold out-of-program PCs to 0.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int PROG_SIZE   = 256
) (
  input logic              clk,
  input logic              reset_n,
  pc_branch_unit_if.slave  bus
);
  logic              exec_cycle, update_cycle;
  pc_src_e           src;
  logic [ADDR_W-1:0] pc_inc, pc_cand, pc_final, stack_top;
  logic              stack_full, stack_empty, push, pop;
  logic [ADDR_W-1:0] next_pc_q;
  logic [2:0]        nzp_q;
  logic              overflow_q, underflow_q;
  logic              unused_alu_bits;

  assign exec_cycle   = bus.enable && (bus.core_state == CORE_STATE_EXECUTE);
  assign update_cycle = bus.enable && (bus.core_state == CORE_STATE_UPDATE);
  assign pc_inc       = bus.current_pc + ADDR_W'(1);
  assign unused_alu_bits = ^bus.alu_out[DATA_W-1:3];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    src = SRC_SEQ;
    if (bus.decoded_ret)                                       src = SRC_RET;
    else if (bus.decoded_call)                                 src = SRC_CALL;
    else if (bus.decoded_pc_mux && |(nzp_q & bus.decoded_nzp)) src = SRC_BRANCH;

    pc_cand = pc_inc;
    case (src)
      SRC_RET:    pc_cand = stack_empty ? pc_inc : stack_top;
      SRC_CALL:   pc_cand = bus.decoded_imm;
      SRC_BRANCH: pc_cand = bus.decoded_imm;
      default:    pc_cand = pc_inc;
    endcase
  end

  assign push = exec_cycle && (src == SRC_CALL) && !stack_full;
  assign pop  = exec_cycle && (src == SRC_RET) && !stack_empty;

  pc_ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (stack_top),
    .depth     (bus.stack_depth),
    .full      (stack_full),
    .empty     (stack_empty)
  );

`ifdef PC_BOUND_CHECK_EN
  logic bound_fault, fault_q;

  assign bound_fault = (32'(pc_cand) >= 32'(PROG_SIZE));
  assign pc_final    = bound_fault ? '0 : pc_cand;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       fault_q <= 1'b0;
    else if (exec_cycle && bound_fault) fault_q <= 1'b1;
  end
  assign bus.pc_fault = fault_q;
`else
  localparam int unused_prog_size = PROG_SIZE;
  assign pc_final     = pc_cand;
  assign bus.pc_fault = 1'b0;
`endif

  // NOTE: registered state uses non-blocking assignments so all flops update
  // together at the edge regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      next_pc_q   <= '0;
      nzp_q       <= 3'b000;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (exec_cycle) begin
      next_pc_q <= pc_final;
      if (src == SRC_RET && stack_empty) underflow_q <= 1'b1;
      if (src == SRC_CALL && stack_full) overflow_q  <= 1'b1;
    end else if (update_cycle && bus.decoded_nzp_write_en) begin
      nzp_q <= {bus.alu_out[NZP_N], bus.alu_out[NZP_Z], bus.alu_out[NZP_P]};
    end
  end

  assign bus.next_pc         = next_pc_q;
  assign bus.nzp             = nzp_q;
  assign bus.stack_overflow  = overflow_q;
  assign bus.stack_underflow = underflow_q;
endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: a queue-based reference model checked on
// every falling edge, plus hand-computed literal expectations.
module tb_pc_branch_unit;
  import pc_branch_unit_pkg::*;

  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 8;
  localparam int STACK_DEPTH = 4;
`ifdef PC_BOUND_CHECK_EN
  localparam int PROG_SIZE = 16;
`else
  localparam int PROG_SIZE = 256;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pc_branch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STACK_DEPTH(STACK_DEPTH)) bus ();

  pc_branch_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STACK_DEPTH(STACK_DEPTH), .PROG_SIZE(PROG_SIZE)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: spec rules over a queue-based return stack.
  logic [7:0] m_pc = '0;
  logic [2:0] m_nzp = '0;
  logic [7:0] m_stack[$];
  logic       m_of = 0, m_uf = 0, m_fault = 0;
  logic [7:0] m_inc;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pc = '0; m_nzp = '0; m_stack.delete(); m_of = 0; m_uf = 0; m_fault = 0;
    end else if (bus.enable && bus.core_state == CORE_STATE_EXECUTE) begin
      m_inc = bus.current_pc + 8'd1;
      if (bus.decoded_ret) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin m_pc = m_inc; m_uf = 1; end
      end else if (bus.decoded_call) begin
        if (m_stack.size() < STACK_DEPTH) m_stack.push_back(m_inc);
        else m_of = 1;
        m_pc = bus.decoded_imm;
      end else if (bus.decoded_pc_mux && (m_nzp & bus.decoded_nzp) != 3'b000) begin
        m_pc = bus.decoded_imm;
      end else begin
        m_pc = m_inc;
      end
`ifdef PC_BOUND_CHECK_EN
      if (int'(m_pc) >= PROG_SIZE) begin m_pc = '0; m_fault = 1; end
`endif
    end else if (bus.enable && bus.core_state == CORE_STATE_UPDATE && bus.decoded_nzp_write_en) begin
      m_nzp = bus.alu_out[2:0];
    end
  end

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("model next_pc", 32'(bus.next_pc), 32'(m_pc));
      check("model nzp", 32'(bus.nzp), 32'(m_nzp));
      check("model depth", 32'(bus.stack_depth), 32'(m_stack.size()));
      check("model overflow", 32'(bus.stack_overflow), 32'(m_of));
      check("model underflow", 32'(bus.stack_underflow), 32'(m_uf));
      check("model pc_fault", 32'(bus.pc_fault), 32'(m_fault));
    end
  end

  function automatic logic [7:0] bnd(input logic [7:0] v);
    return (int'(v) >= PROG_SIZE) ? 8'h00 : v;
  endfunction

  task automatic drive(input logic [2:0] st, input logic [7:0] pc, input logic br,
                       input logic [2:0] mask, input logic [7:0] imm, input logic call,
                       input logic ret, input logic we, input logic [7:0] alu, input logic en);
    bus.core_state = st;   bus.current_pc = pc;   bus.decoded_pc_mux = br;
    bus.decoded_nzp = mask; bus.decoded_imm = imm; bus.decoded_call = call;
    bus.decoded_ret = ret; bus.decoded_nzp_write_en = we; bus.alu_out = alu;
    bus.enable = en;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic op(input logic [7:0] pc, input logic br, input logic [2:0] mask,
                    input logic [7:0] imm, input logic call, input logic ret);
    drive(CORE_STATE_EXECUTE, pc, br, mask, imm, call, ret, 1'b0, 8'h00, 1'b1);
    tick();
  endtask

  logic [7:0] ret_exp [4];

  initial begin
    ret_exp = '{8'h81, 8'h71, 8'h61, 8'h51};
    reset_n = 1'b0;
    drive(3'b000, 8'h00, 0, 3'b000, 8'h00, 0, 0, 0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    chk_en = 1'b1;
    check("reset next_pc", 32'(bus.next_pc), 32'h0);
    check("reset depth", 32'(bus.stack_depth), 32'h0);
    check("reset nzp", 32'(bus.nzp), 32'h0);

    // Sequential advance, then asynchronous reset between edges.
    op(8'h05, 0, 3'b000, 8'h00, 0, 0);
    check("seq 05->06", 32'(bus.next_pc), 32'(bnd(8'h06)));
    op(8'h30, 0, 3'b000, 8'h00, 0, 0);
    #1 reset_n = 1'b0;
    #1 check("async reset next_pc", 32'(bus.next_pc), 32'h0);
    @(negedge clk);
    #1 reset_n = 1'b1;

    // NZP write then branch.
    drive(CORE_STATE_UPDATE, 8'h00, 0, 3'b000, 8'h00, 0, 0, 1'b1, 8'hA2, 1'b1);
    tick();
    check("nzp write", 32'(bus.nzp), 32'b010);
    check("update holds pc", 32'(bus.next_pc), 32'h0);
    op(8'h07, 1, 3'b010, 8'h20, 0, 0);
    check("branch taken", 32'(bus.next_pc), 32'(bnd(8'h20)));
    op(8'h21, 1, 3'b101, 8'h60, 0, 0);
    check("branch not taken", 32'(bus.next_pc), 32'(bnd(8'h22)));

    // Single CALL / RET.
    op(8'h10, 0, 3'b000, 8'h40, 1, 0);
    check("call target", 32'(bus.next_pc), 32'(bnd(8'h40)));
    check("call depth", 32'(bus.stack_depth), 32'd1);
    op(8'h45, 0, 3'b000, 8'h00, 0, 1);
    check("ret addr", 32'(bus.next_pc), 32'(bnd(8'h11)));
    check("ret depth", 32'(bus.stack_depth), 32'd0);

    // Fill past capacity, then drain past empty.
    for (int i = 0; i < 5; i++) begin
      op(8'h50 + 8'(i * 16), 0, 3'b000, 8'hA0 + 8'(i), 1, 0);
      check("burst call target", 32'(bus.next_pc), 32'(bnd(8'hA0 + 8'(i))));
      check("burst call depth", 32'(bus.stack_depth), (i < 4) ? 32'(i + 1) : 32'd4);
    end
    check("overflow set", 32'(bus.stack_overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      op(8'hC0, 0, 3'b000, 8'h00, 0, 1);
      check("burst ret addr", 32'(bus.next_pc), 32'(bnd(ret_exp[i])));
    end
    check("underflow clear", 32'(bus.stack_underflow), 32'd0);
    op(8'hC8, 0, 3'b000, 8'h00, 0, 1);
    check("underflow set", 32'(bus.stack_underflow), 32'd1);
    check("underflow pc", 32'(bus.next_pc), 32'(bnd(8'hC9)));

    // Wrap at max address.
    op(8'hFF, 0, 3'b000, 8'h00, 0, 0);
    check("wrap FF->00", 32'(bus.next_pc), 32'h00);
`ifdef PC_BOUND_CHECK_EN
    op(8'h0F, 0, 3'b000, 8'h00, 0, 0);
    check("bound fold", 32'(bus.next_pc), 32'h00);
    check("bound fault", 32'(bus.pc_fault), 32'd1);
`else
    check("pc_fault tied low", 32'(bus.pc_fault), 32'd0);
`endif

    // Disabled lane holds everything, even with call/ret/nzp write asserted.
    op(8'h02, 0, 3'b000, 8'h08, 1, 0);
    check("call before hold", 32'(bus.next_pc), 32'h08);
    drive(CORE_STATE_EXECUTE, 8'h0A, 1, 3'b111, 8'h0C, 1, 1, 1, 8'h04, 1'b0);
    tick();
    check("disabled exec pc", 32'(bus.next_pc), 32'h08);
    check("disabled exec depth", 32'(bus.stack_depth), 32'd1);
    drive(CORE_STATE_UPDATE, 8'h0A, 0, 3'b000, 8'h00, 0, 0, 1, 8'h04, 1'b0);
    tick();
    check("disabled update nzp", 32'(bus.nzp), 32'b010);
    // Other core states hold as well.
    drive(3'b001, 8'h0A, 0, 3'b000, 8'h0E, 1, 0, 1, 8'h01, 1'b1);
    tick();
    check("idle state pc", 32'(bus.next_pc), 32'h08);
    check("idle state nzp", 32'(bus.nzp), 32'b010);

    // CALL and RET together: RET wins, no push.
    op(8'h09, 0, 3'b000, 8'h33, 1, 1);
    check("call+ret pops", 32'(bus.next_pc), 32'h03);
    check("call+ret depth", 32'(bus.stack_depth), 32'd0);
    check("flags sticky of", 32'(bus.stack_overflow), 32'd1);
    check("flags sticky uf", 32'(bus.stack_underflow), 32'd1);

    drive(3'b000, 8'h00, 0, 3'b000, 8'h00, 0, 0, 0, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
